// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8-bit UART transmitter, LSB first. A FIFO of DEPTH bytes sits in front of the serialiser.
// Ports: wb_clk_i/wb_rst_i (clock, sync active-high reset); clk_div (cycles per bit, 0 acts as 1);
//        tx_data/tx_valid/tx_ready (byte push port, ready = !full); tx_o (serial line, idles high);
//        busy (frame in flight or FIFO non-empty); fifo_level (occupancy 0..DEPTH).
// Optional parity: define UART_TX_PARITY_EN to insert a parity bit after D7 (PARITY_ODD selects odd).
module uart_tx_fifo #(
  parameter int DEPTH      = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [15:0]              clk_div,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     tx_o,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx_fifo: illegal parameter combination");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par_bit;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          full;
  state_t        state;
  logic [15:0]   baud_cnt, div_lat, div_eff;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic          push, pop, bit_end, last_stop, line;

  assign tx_ready   = !full;
  assign fifo_level = count;
  assign push       = tx_valid && !full;
  assign bit_end    = (baud_cnt == 16'd0);
  assign last_stop  = (STOP_BITS == 1) || stop_idx;
  assign div_eff    = (clk_div == 16'd0) ? 16'd1 : clk_div;

  // A new frame is loaded from IDLE, or straight out of the final stop period.
  assign pop = (count != '0) &&
               ((state == IDLE) || ((state == STOP) && bit_end && last_stop));

  assign count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  // Line level for the current state; tx_o registers it, so every bit is held
  // exactly one bit period on the pin, delayed one cycle behind the state.
  always_comb begin
    line = 1'b1;
    case (state)
      START:  line = 1'b0;
      DATA:   line = shreg[0];
`ifdef UART_TX_PARITY_EN
      PARITY: line = par_bit;
`endif
      default: line = 1'b1;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      state    <= IDLE;
      baud_cnt <= 16'd0;
      div_lat  <= 16'd1;
      shreg    <= 8'd0;
      bit_idx  <= 3'd0;
      stop_idx <= 1'b0;
      tx_o     <= 1'b1;
      busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      tx_o  <= line;
      busy  <= (state != IDLE) || (count != '0);

      if (pop) begin
        // Frame load: divisor is sampled here only, so mid-frame changes wait.
        shreg    <= mem[rd_ptr];
        div_lat  <= div_eff;
        baud_cnt <= div_eff - 16'd1;
        state    <= START;
`ifdef UART_TX_PARITY_EN
        par_bit  <= (^mem[rd_ptr]) ^ (PARITY_ODD != 0);
`endif
      end else if (state != IDLE) begin
        if (!bit_end) begin
          baud_cnt <= baud_cnt - 16'd1;
        end else begin
          baud_cnt <= div_lat - 16'd1;
          case (state)
            START: begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end
            DATA: begin
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state <= PARITY;
`else
                state    <= STOP;
                stop_idx <= 1'b0;
`endif
              end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
              state    <= STOP;
              stop_idx <= 1'b0;
            end
`endif
            STOP: begin
              if (!last_stop) stop_idx <= 1'b1;
              else            state    <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam bit PODD  = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   clk_div = 16'd4;
  logic [7:0]    tx_data = 8'd0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, tx_o, busy;
  logic [LW-1:0] fifo_level;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  bit mon_on = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .STOP_BITS(1), .PARITY_ODD(PODD)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .clk_div(clk_div), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_o(tx_o), .busy(busy),
    .fifo_level(fifo_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity, one stop bit.
  // Waits up to 'limit' negedges for the start bit; limit=1 means no idle gap allowed.
  task automatic expect_frame(input logic [7:0] d, input int cpb, input int limit, input string name);
    logic [10:0] bits;
    logic bad;
    int w, nb;
    bit ok;
    nb   = 10 + PB;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (PB == 1) bits[9] = (^d) ^ PODD;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (tx_o !== 1'b0 && w < limit);
    if (tx_o !== 1'b0) begin
      chk({name, " start"}, tx_o, 1'b0);
      return;
    end
    for (int b = 0; b < nb; b++) begin
      ok = 1'b1;
      bad = bits[b];
      for (int c = 0; c < cpb; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (tx_o !== bits[b]) begin ok = 1'b0; bad = tx_o; end
      end
      chk($sformatf("%s bit%0d", name, b), ok ? bits[b] : bad, bits[b]);
    end
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (busy !== 1'b0 && w < 20000) begin @(negedge clk); w++; end
    if (busy !== 1'b0) chk({name, " idle timeout"}, busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  // Table of single-frame vectors: line holds {stop, data, start} LSB = start.
  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    int          cpb;
    logic [9:0]  line;
    logic        par_even;
  } vec_t;
  vec_t vecs[8];

  // tx_ready must always mirror "FIFO not full".
  always @(negedge clk) begin
    if (mon_on) chk("ready_vs_level", tx_ready, (fifo_level != LW'(DEPTH)));
  end

  initial begin
    logic exp_bit;
    bit ok, saw_full, done;
    logic bad;
    int w, n_rand, rdiv;

    vecs[0] = '{8'h55, 16'd4, 4, 10'h2AA, 1'b0};
    vecs[1] = '{8'hA3, 16'd2, 2, 10'h346, 1'b0};
    vecs[2] = '{8'h0F, 16'd3, 3, 10'h21E, 1'b0};
    vecs[3] = '{8'h00, 16'd0, 1, 10'h200, 1'b0};
    vecs[4] = '{8'hFF, 16'd1, 1, 10'h3FE, 1'b0};
    vecs[5] = '{8'h81, 16'd3, 3, 10'h302, 1'b0};
    vecs[6] = '{8'h07, 16'd2, 2, 10'h20E, 1'b1};
    vecs[7] = '{8'h03, 16'd5, 5, 10'h206, 1'b0};

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst tx_o", tx_o, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst level", fifo_level, 0);
    chk("rst ready", tx_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single frames with latency and busy checks
    for (int i = 0; i < 8; i++) begin
      clk_div  = vecs[i].div;
      tx_data  = vecs[i].data;
      tx_valid = 1'b1;
      chk($sformatf("v%0d ready", i), tx_ready, 1'b1);
      @(negedge clk);
      tx_valid = 1'b0;
      chk($sformatf("v%0d level1", i), fifo_level, 1);
      @(negedge clk);
      chk($sformatf("v%0d tx_o still high", i), tx_o, 1'b1);
      chk($sformatf("v%0d busy", i), busy, 1'b1);
      for (int b = 0; b < 10 + PB; b++) begin
        if (b < 9)                 exp_bit = vecs[i].line[b];
        else if (PB == 1 && b == 9) exp_bit = vecs[i].par_even ^ PODD;
        else                       exp_bit = 1'b1;
        ok = 1'b1;
        bad = exp_bit;
        for (int c = 0; c < vecs[i].cpb; c++) begin
          @(negedge clk);
          if (tx_o !== exp_bit) begin ok = 1'b0; bad = tx_o; end
        end
        chk($sformatf("v%0d bit%0d", i, b), ok ? exp_bit : bad, exp_bit);
      end
      chk($sformatf("v%0d busy end of frame", i), busy, 1'b1);
      @(negedge clk);
      chk($sformatf("v%0d busy after frame", i), busy, 1'b0);
      chk($sformatf("v%0d level after", i), fifo_level, 0);
      chk($sformatf("v%0d line idle", i), tx_o, 1'b1);
      @(negedge clk);
    end

    // Back-to-back frames, no idle gap
    clk_div = 16'd8;
    tx_valid = 1'b1; tx_data = 8'hA3;
    @(negedge clk); tx_data = 8'h0F;
    @(negedge clk); tx_valid = 1'b0;
    expect_frame(8'hA3, 8, 10, "b2b first");
    expect_frame(8'h0F, 8, 1, "b2b second");
    wait_idle("b2b");

    // Hold tx_valid with DEPTH+3 bytes: FIFO fills, nothing lost or duplicated
    clk_div = 16'd16;
    saw_full = 1'b0;
    done = 1'b0;
    fork
      begin
        tx_valid = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) begin
          tx_data = 8'(8'h30 + i);
          w = 0;
          while (!tx_ready && w < 5000) begin @(negedge clk); w++; end
          exp_q.push_back(tx_data);
          @(negedge clk);
        end
        tx_valid = 1'b0;
      end
      begin
        for (int i = 0; i < DEPTH + 3; i++) begin
          w = 0;
          while (exp_q.size() == 0 && w < 5000) begin @(negedge clk); w++; end
          if (exp_q.size() == 0) chk("fill queue empty", 0, 1);
          else expect_frame(exp_q.pop_front(), 16, (i == 0) ? 20 : 1, $sformatf("fill%0d", i));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (fifo_level == LW'(DEPTH) && !saw_full) begin
            saw_full = 1'b1;
            chk("full ready low", tx_ready, 1'b0);
          end
        end
      end
    join
    chk("fifo reached full", saw_full, 1'b1);
    wait_idle("fill");

    // Divisor change mid-frame applies from the next frame
    clk_div = 16'd4;
    tx_valid = 1'b1; tx_data = 8'h3C;
    @(negedge clk); tx_data = 8'hC5;
    @(negedge clk); tx_valid = 1'b0;
    fork
      begin
        expect_frame(8'h3C, 4, 10, "div old");
        expect_frame(8'hC5, 10, 1, "div new");
      end
      begin
        repeat (15) @(negedge clk);
        clk_div = 16'd10;
      end
    join
    wait_idle("div");

    // Reset during D3 of 0xFF with three bytes queued
    clk_div = 16'd4;
    tx_valid = 1'b1; tx_data = 8'hFF;
    @(negedge clk); tx_data = 8'h01;
    @(negedge clk); tx_data = 8'h02;
    @(negedge clk); tx_data = 8'h03;
    @(negedge clk); tx_valid = 1'b0;
    repeat (16) @(negedge clk);
    chk("rst mid D3 line", tx_o, 1'b1);
    chk("rst mid level", fifo_level, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst mid tx_o", tx_o, 1'b1);
    chk("rst mid level0", fifo_level, 0);
    chk("rst mid busy", busy, 1'b0);
    chk("rst mid ready", tx_ready, 1'b1);
    rst = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    chk("no frames after reset", ok, 1'b1);

    // Randomised traffic against the queue model
    n_rand = 40;
    rdiv = $urandom_range(1, 3);
    clk_div = 16'(rdiv);
    mon_on = 1'b1;
    fork
      begin
        int got;
        got = 0;
        while (got < n_rand) begin
          tx_valid = 1'($urandom_range(0, 1));
          tx_data  = 8'($urandom);
          if (tx_valid && tx_ready) begin
            exp_q.push_back(tx_data);
            got++;
          end
          @(negedge clk);
        end
        tx_valid = 1'b0;
      end
      begin
        for (int i = 0; i < n_rand; i++) begin
          w = 0;
          while (exp_q.size() == 0 && w < 5000) begin @(negedge clk); w++; end
          if (exp_q.size() == 0) chk("rand queue empty", 0, 1);
          else expect_frame(exp_q.pop_front(), rdiv, 3000, $sformatf("rand%0d", i));
        end
      end
    join
    mon_on = 1'b0;
    wait_idle("rand");
    chk("rand level end", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
